// File: rtl/multicycle_controller.sv
// Multicycle control unit: IDLE/DECODE/EXEC/MEM/WB sequencer that turns a latched
// instruction into datapath strobes, with saturating illegal-opcode accounting.
module multicycle_controller #(
    parameter int MEM_LAT   = 1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [31:0]          Instruction,
    input  logic                 InstrValid,
    input  logic                 BrTaken,
    output logic                 Busy,
    output logic                 Done,
    output logic [1:0]           RegDst,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic                 Branch,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 PCWrite,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           PCSrc,
    output logic [1:0]           MemSize,
    output logic                 Debug,
    output logic [ILL_CNT_W-1:0] IllegalCount
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {
        K_RTYPE, K_JR, K_ADDI, K_LOGI, K_LOAD, K_STORE, K_BRANCH, K_J, K_JAL, K_ILL
    } kind_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t                 state_q, state_d;
    logic [31:0]            ir_q, ir_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ILL_CNT_W-1:0]   ill_q, ill_d;
    kind_t                  kind;
    logic                   mem_last;
    logic [1:0]             mem_size;
    logic                   ir_unused;

    // Only opcode and funct steer control; the register fields belong to the datapath.
    assign ir_unused = ^ir_q[25:6];
    assign mem_last  = (cnt_q == 4'd0);

    always_comb begin
        kind = K_ILL;
        case (ir_q[31:26])
            6'b000000: kind = (ir_q[5:0] == 6'b001000) ? K_JR : K_RTYPE;
            6'b001000: kind = K_ADDI;
            6'b001100, 6'b001101, 6'b001110: kind = K_LOGI;
            6'b100011, 6'b100001, 6'b100000: kind = K_LOAD;
            6'b101011, 6'b101001, 6'b101000: kind = K_STORE;
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: kind = K_BRANCH;
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    // Loads and stores share the size encoding in opcode[1:0]: 11 word, 01 half, 00 byte.
    always_comb begin
        case (ir_q[27:26])
            2'b11:   mem_size = 2'b00;
            2'b01:   mem_size = 2'b01;
            default: mem_size = 2'b10;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            ill_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (InstrValid) state_d = S_DECODE;
            S_DECODE: state_d = (kind == K_ILL) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (kind)
                    K_RTYPE, K_ADDI, K_LOGI: state_d = S_WB;
                    K_LOAD, K_STORE:         state_d = S_MEM;
                    default:                 state_d = S_IDLE;
                endcase
            end
            S_MEM:    if (mem_last) state_d = (kind == K_LOAD) ? S_WB : S_IDLE;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The MEM counter is reloaded every EXEC so it is fresh on MEM entry.
    always_comb begin
        ir_d  = ir_q;
        cnt_d = cnt_q;
        ill_d = ill_q;
        if (state_q == S_IDLE && InstrValid) ir_d = Instruction;
        if (state_q == S_EXEC) cnt_d = CNT_INIT;
        else if (state_q == S_MEM && !mem_last) cnt_d = cnt_q - 4'd1;
        if (state_q == S_DECODE && kind == K_ILL && ill_q != '1)
            ill_d = ill_q + ILL_CNT_W'(1);
    end

    always_comb begin
        Busy     = (state_q != S_IDLE);
        Done     = 1'b0;
        RegDst   = 2'b00;
        ALUOp    = 2'b00;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        MemtoReg = 2'b00;
        PCSrc    = 2'b00;
        MemSize  = 2'b00;
        Debug    = 1'b0;
        case (state_q)
            S_DECODE: begin
                if (kind == K_ILL) begin
                    Debug   = 1'b1;
                    Done    = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_EXEC: begin
                case (kind)
                    K_RTYPE: ALUOp = 2'b10;
                    K_JR: begin
                        PCSrc   = 2'b11;
                        Done    = 1'b1;
                        PCWrite = 1'b1;
                    end
                    K_ADDI: ALUSrc = 1'b1;
                    K_LOGI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    K_LOAD, K_STORE: ALUSrc = 1'b1;
                    K_BRANCH: begin
                        Branch  = 1'b1;
                        ALUOp   = 2'b01;
                        PCSrc   = BrTaken ? 2'b01 : 2'b00;
                        Done    = 1'b1;
                        PCWrite = 1'b1;
                    end
                    K_J: begin
                        PCSrc   = 2'b10;
                        Done    = 1'b1;
                        PCWrite = 1'b1;
                    end
                    K_JAL: begin
                        PCSrc    = 2'b10;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                        RegWrite = 1'b1;
                        Done     = 1'b1;
                        PCWrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                MemSize = mem_size;
                MemRead = (kind == K_LOAD);
                if (kind == K_STORE && mem_last) begin
                    MemWrite = 1'b1;
                    Done     = 1'b1;
                    PCWrite  = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                Done     = 1'b1;
                PCWrite  = 1'b1;
                if (kind == K_LOAD) begin
                    MemtoReg = 2'b00;
                    RegDst   = 2'b00;
                end else begin
                    MemtoReg = 2'b01;
                    RegDst   = (kind == K_RTYPE) ? 2'b01 : 2'b00;
                end
            end
            default: ;
        endcase
    end

    assign IllegalCount = ill_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions compared cycle by
// cycle against a latency/strobe table model derived from instruction classes.
module tb_multicycle_controller;

    localparam int LAT = 3;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic          valid = 1'b0;
    logic          bt = 1'b0;
    logic          Busy, Done, ALUSrc, Branch, MemRead, MemWrite, RegWrite, PCWrite, Debug;
    logic [1:0]    RegDst, ALUOp, MemtoReg, PCSrc, MemSize;
    logic [CW-1:0] IllegalCount;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] regdst;
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic [1:0] memtoreg;
        logic [1:0] pcsrc;
        logic [1:0] memsize;
        logic       debug;
    } outs_t;

    outs_t got;
    assign got = {Busy, Done, RegDst, ALUOp, ALUSrc, Branch, MemRead, MemWrite,
                  RegWrite, PCWrite, MemtoReg, PCSrc, MemSize, Debug};

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;

    multicycle_controller #(.MEM_LAT(LAT), .ILL_CNT_W(CW)) dut (
        .Clk(clk), .Rst(rst), .Instruction(instr), .InstrValid(valid), .BrTaken(bt),
        .Busy(Busy), .Done(Done), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .MemSize(MemSize),
        .Debug(Debug), .IllegalCount(IllegalCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic string cls(input logic [31:0] ins);
        case (ins[31:26])
            6'b000000: return (ins[5:0] == 6'b001000) ? "JR" : "R";
            6'b001000: return "ADDI";
            6'b001100, 6'b001101, 6'b001110: return "LOGI";
            6'b100011, 6'b100001, 6'b100000: return "LD";
            6'b101011, 6'b101001, 6'b101000: return "ST";
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: return "BR";
            6'b000010: return "J";
            6'b000011: return "JAL";
            default:   return "ILL";
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] ins);
        string c = cls(ins);
        if (c == "ILL") return 1;
        if (c == "BR" || c == "J" || c == "JAL" || c == "JR") return 2;
        if (c == "ST") return 2 + LAT;
        if (c == "LD") return 3 + LAT;
        return 3;
    endfunction

    function automatic logic [1:0] size_of(input logic [5:0] op);
        if (op == 6'b100011 || op == 6'b101011) return 2'b00;
        if (op == 6'b100001 || op == 6'b101001) return 2'b01;
        return 2'b10;
    endfunction

    // Expected outputs k cycles after the accept edge.
    function automatic outs_t model(input logic [31:0] ins, input int k, input logic b);
        outs_t e = '0;
        string c = cls(ins);
        int    lat = model_lat(ins);
        e.busy = 1'b1;
        if (k == lat) begin
            e.done    = 1'b1;
            e.pcwrite = 1'b1;
        end
        if (c == "ILL") begin
            e.debug = (k == 1);
        end else if (k == 2) begin
            if (c == "R") e.aluop = 2'b10;
            if (c == "JR") e.pcsrc = 2'b11;
            if (c == "ADDI" || c == "LD" || c == "ST") e.alusrc = 1'b1;
            if (c == "LOGI") begin e.alusrc = 1'b1; e.aluop = 2'b11; end
            if (c == "BR") begin
                e.branch = 1'b1;
                e.aluop  = 2'b01;
                e.pcsrc  = b ? 2'b01 : 2'b00;
            end
            if (c == "J") e.pcsrc = 2'b10;
            if (c == "JAL") begin
                e.pcsrc = 2'b10; e.regdst = 2'b10; e.memtoreg = 2'b10; e.regwrite = 1'b1;
            end
        end else if ((c == "LD" || c == "ST") && k >= 3 && k <= 2 + LAT) begin
            e.memsize  = size_of(ins[31:26]);
            e.memread  = (c == "LD");
            e.memwrite = (c == "ST") && (k == 2 + LAT);
        end else if (k == lat && k >= 3) begin
            e.regwrite = 1'b1;
            e.memtoreg = (c == "LD") ? 2'b00 : 2'b01;
            e.regdst   = (c == "R") ? 2'b01 : 2'b00;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [5:0]  op;
        if ($urandom_range(0, 5) == 0) begin
            do op = 6'($urandom); while (cls({op, 26'b0}) != "ILL");
        end else begin
            do op = 6'($urandom); while (cls({op, 26'b0}) == "ILL");
        end
        r[31:26] = op;
        if (op == 6'b000000 && $urandom_range(0, 3) == 0) r[5:0] = 6'b001000;
        return r;
    endfunction

    task automatic run_instr(input logic [31:0] ins, input logic b, input string tag);
        outs_t e;
        int    lat = model_lat(ins);
        @(negedge clk);
        instr = ins; valid = 1'b1; bt = b;
        @(posedge clk); #1;
        valid = 1'b0; instr = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            e = model(ins, k, b);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s k=%0d ins=%h got=%h exp=%h", tag, k, ins, got, e);
            end
        end
        if (cls(ins) == "ILL" && mcnt < CNT_MAX) mcnt++;
        @(posedge clk); #1;
        checks++;
        if (got !== outs_t'(0)) begin
            errors++;
            $display("FAIL %s_idle ins=%h got=%h exp=0", tag, ins, got);
        end
        checks++;
        if (IllegalCount !== CW'(mcnt)) begin
            errors++;
            $display("FAIL %s_illcnt got=%0d exp=%0d", tag, IllegalCount, mcnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; instr = 32'hFC000000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got !== outs_t'(0) || IllegalCount !== '0) begin
            errors++;
            $display("FAIL reset got=%h cnt=%0d exp=0", got, IllegalCount);
        end
        rst = 1'b0; valid = 1'b0;
    endtask

    task automatic test_load();
        run_instr(32'h8C820004, 1'($urandom), "lw");
        run_instr(32'h84820002, 1'($urandom), "lh");
        run_instr(32'h80820001, 1'($urandom), "lb");
        run_instr(32'hA4820002, 1'($urandom), "sh");
    endtask

    task automatic test_branch();
        run_instr(32'h10220003, 1'b1, "beq_taken");
        run_instr(32'h10220003, 1'b0, "beq_not");
    endtask

    task automatic test_jump();
        run_instr(32'h0C000010, 1'b0, "jal");
        run_instr(32'h03E00008, 1'b1, "jr");
        run_instr(32'h08000004, 1'b0, "j");
        run_instr(32'h30A5000F, 1'b0, "andi");
    endtask

    task automatic test_hold();
        logic [31:0] add_w = 32'h00851020;
        logic [31:0] ill_w = 32'hFC000000;
        outs_t e;
        @(negedge clk);
        instr = add_w; valid = 1'b1; bt = 1'b0;
        @(posedge clk); #1;
        instr = ill_w;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            e = model(add_w, k, 1'b0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL hold_add k=%0d got=%h exp=%h", k, got, e);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (got !== outs_t'(0)) begin
            errors++;
            $display("FAIL hold_idle got=%h exp=0", got);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        e = model(ill_w, 1, 1'b0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL hold_next_accept got=%h exp=%h", got, e);
        end
        if (mcnt < CNT_MAX) mcnt++;
        @(posedge clk); #1;
        checks++;
        if (got !== outs_t'(0) || IllegalCount !== CW'(mcnt)) begin
            errors++;
            $display("FAIL hold_after got=%h cnt=%0d exp=0 cnt=%0d", got, IllegalCount, mcnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) run_instr(rand_instr(), 1'($urandom), "rand");
    endtask

    task automatic test_illegal_sat();
        for (int i = 0; i < 260; i++)
            run_instr({6'b111111, 26'($urandom)}, 1'($urandom), "illegal");
        checks++;
        if (IllegalCount !== 8'hFF) begin
            errors++;
            $display("FAIL illegal_sat got=%0d exp=255", IllegalCount);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [31:0] sw_w = 32'hAC820004;
        outs_t e;
        @(negedge clk);
        instr = sw_w; valid = 1'b1; bt = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            e = model(sw_w, k, 1'b0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rst_sw k=%0d got=%h exp=%h", k, got, e);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mcnt = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got !== outs_t'(0) || IllegalCount !== '0) begin
                errors++;
                $display("FAIL rst_mid_mem c=%0d got=%h cnt=%0d exp=0", k, got, IllegalCount);
            end
            @(posedge clk); #1;
        end
        run_instr(32'h00851020, 1'b0, "after_rst");
        run_instr(32'hAC820004, 1'b0, "sw_after_rst");
    endtask

    initial begin
        test_reset();
        test_load();
        test_branch();
        test_jump();
        test_hold();
        test_back_to_back();
        test_illegal_sat();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
